// File: rtl/nf_mem_arb.sv
`timescale 1ns/1ps
// nf_mem_arb: arbitrates IF and LSU onto the single shared memory port.
// LSU has priority; a starvation counter forces an IF grant after STARVE_MAX LSU wins.
module nf_mem_arb #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rd,
   input  logic        lsu_req,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wd,
   input  logic        lsu_we,
   input  logic [1:0]  lsu_size,
   output logic        lsu_ack,
   output logic [31:0] lsu_rd,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   output logic [1:0]  mem_size,
   input  logic        mem_ack,
   input  logic [31:0] mem_rd,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUS  = 2'd1,
      LSU_BUS = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wd_q, mem_wd_d;
   logic        mem_we_q, mem_we_d;
   logic [1:0]  mem_size_q, mem_size_d;
   logic        if_ack_q, if_ack_d;
   logic        lsu_ack_q, lsu_ack_d;
   logic [31:0] if_rd_q, if_rd_d;
   logic [31:0] lsu_rd_q, lsu_rd_d;
   logic        busy_q, busy_d;
   logic        lsu_wins;

   // LSU wins unless IF is also waiting and has already been passed over STARVE_MAX times.
   assign lsu_wins = lsu_req && (!if_req || (starve_q < STARVE_LIM));

   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      mem_wd_d   = mem_wd_q;
      mem_we_d   = mem_we_q;
      mem_size_d = mem_size_q;
      if_rd_d    = if_rd_q;
      lsu_rd_d   = lsu_rd_q;
      if_ack_d   = 1'b0;
      lsu_ack_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (lsu_wins) begin
               state_d    = LSU_BUS;
               mem_req_d  = 1'b1;
               mem_addr_d = lsu_addr;
               mem_wd_d   = lsu_wd;
               mem_we_d   = lsu_we;
               mem_size_d = lsu_size;
               if (!if_req)
                  starve_d = 4'd0;
               else if (starve_q >= STARVE_LIM)
                  starve_d = STARVE_LIM;
               else
                  starve_d = starve_q + 4'd1;
            end else if (if_req) begin
               state_d    = IF_BUS;
               mem_req_d  = 1'b1;
               mem_addr_d = if_addr;
               mem_wd_d   = 32'd0;
               mem_we_d   = 1'b0;
               mem_size_d = 2'b10;
               starve_d   = 4'd0;
            end
         end
         IF_BUS: begin
            if (mem_ack) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               if_rd_d   = mem_rd;
               if_ack_d  = 1'b1;
            end
         end
         LSU_BUS: begin
            if (mem_ack) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               lsu_rd_d  = mem_rd;
               lsu_ack_d = 1'b1;
            end
         end
         // Requests are ignored here so a req still held from the finished access cannot re-grant.
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         starve_q   <= 4'd0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= 32'd0;
         mem_wd_q   <= 32'd0;
         mem_we_q   <= 1'b0;
         mem_size_q <= 2'b00;
         if_ack_q   <= 1'b0;
         lsu_ack_q  <= 1'b0;
         if_rd_q    <= 32'd0;
         lsu_rd_q   <= 32'd0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         mem_wd_q   <= mem_wd_d;
         mem_we_q   <= mem_we_d;
         mem_size_q <= mem_size_d;
         if_ack_q   <= if_ack_d;
         lsu_ack_q  <= lsu_ack_d;
         if_rd_q    <= if_rd_d;
         lsu_rd_q   <= lsu_rd_d;
         busy_q     <= busy_d;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign mem_wd   = mem_wd_q;
   assign mem_we   = mem_we_q;
   assign mem_size = mem_size_q;
   assign if_ack   = if_ack_q;
   assign lsu_ack  = lsu_ack_q;
   assign if_rd    = if_rd_q;
   assign lsu_rd   = lsu_rd_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_nf_mem_arb.sv
`timescale 1ns/1ps
// tb_nf_mem_arb: directed scenarios then random traffic, checked against a
// transaction-level reference model of the arbiter.
module tb_nf_mem_arb;
   localparam int SMAX = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        if_req = 1'b0, lsu_req = 1'b0, lsu_we = 1'b0, mem_ack = 1'b0;
   logic [31:0] if_addr = '0, lsu_addr = '0, lsu_wd = '0, mem_rd = '0;
   logic [1:0]  lsu_size = '0;
   logic        if_ack, lsu_ack, mem_req, mem_we, busy;
   logic [31:0] if_rd, lsu_rd, mem_addr, mem_wd;
   logic [1:0]  mem_size;

   nf_mem_arb #(.STARVE_MAX(SMAX)) dut (
      .clk(clk), .resetn(resetn),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rd(if_rd),
      .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_wd(lsu_wd), .lsu_we(lsu_we),
      .lsu_size(lsu_size), .lsu_ack(lsu_ack), .lsu_rd(lsu_rd),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
      .mem_size(mem_size), .mem_ack(mem_ack), .mem_rd(mem_rd), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: one transaction in flight at a time, one response cycle after it.
   bit          m_fly, m_resp;
   int          m_who;     // 1 = IF, 2 = LSU
   int          m_streak;  // LSU wins in a row while IF waited
   logic [31:0] m_addr, m_wd, m_ifrd, m_lsurd;
   logic        m_we, m_ifack, m_lsuack;
   logic [1:0]  m_size;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fly = 0; m_resp = 0; m_who = 0; m_streak = 0;
      m_addr = '0; m_wd = '0; m_we = 0; m_size = '0;
      m_ifrd = '0; m_lsurd = '0; m_ifack = 0; m_lsuack = 0;
   endtask

   task automatic check_zero();
      chk("rst_mem_req", 32'(mem_req), 0);   chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wd", mem_wd, 0);          chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_size", 32'(mem_size), 0); chk("rst_if_ack", 32'(if_ack), 0);
      chk("rst_lsu_ack", 32'(lsu_ack), 0);   chk("rst_if_rd", if_rd, 0);
      chk("rst_lsu_rd", lsu_rd, 0);          chk("rst_busy", 32'(busy), 0);
   endtask

   // Apply the model to the inputs of the current cycle, advance one clock, compare.
   task automatic tick();
      bit ia = 0, la = 0;
      bit lsu_wins;
      if (m_fly && mem_ack) begin
         if (m_who == 1) begin ia = 1; m_ifrd = mem_rd; end
         else begin la = 1; m_lsurd = mem_rd; end
         m_fly = 0; m_resp = 1;
      end else if (m_resp) begin
         m_resp = 0;
      end else if (!m_fly && (if_req || lsu_req)) begin
         lsu_wins = lsu_req && (!if_req || m_streak < SMAX);
         if (lsu_wins) begin
            m_who = 2; m_addr = lsu_addr; m_wd = lsu_wd; m_we = lsu_we; m_size = lsu_size;
            m_streak = if_req ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
         end else begin
            m_who = 1; m_addr = if_addr; m_wd = 0; m_we = 0; m_size = 2'b10;
            m_streak = 0;
         end
         m_fly = 1;
      end
      m_ifack = ia; m_lsuack = la;
      @(posedge clk); #1;
      chk("mem_req", 32'(mem_req), 32'(m_fly));
      chk("busy", 32'(busy), 32'(m_fly || m_resp));
      chk("if_ack", 32'(if_ack), 32'(m_ifack));
      chk("lsu_ack", 32'(lsu_ack), 32'(m_lsuack));
      chk("if_rd", if_rd, m_ifrd);
      chk("lsu_rd", lsu_rd, m_lsurd);
      if (m_fly) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_wd", mem_wd, m_wd);
         chk("mem_we", 32'(mem_we), 32'(m_we));
         chk("mem_size", 32'(mem_size), 32'(m_size));
      end
   endtask

   task automatic drain();
      int b = 0;
      while ((m_fly || m_resp) && b < 20) begin
         mem_ack = m_fly; mem_rd = $urandom; tick(); b++;
      end
      mem_ack = 0;
      if (m_fly || m_resp) begin
         n_bad++;
         $display("FAIL drain_timeout: transaction still open after %0d cycles", b);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gcnt;
      int gord[6];
      int gexp[6];
      logic prev_req;

      model_reset();
      // Reset values
      repeat (2) @(posedge clk);
      #1 check_zero();
      resetn = 1'b1;
      @(posedge clk); #1;

      // Single fetch, memory acks in cycle 3
      if_req = 1; if_addr = 32'h100;
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk("fetch_addr", mem_addr, 32'h100);
         chk("fetch_we", 32'(mem_we), 0);
         chk("fetch_size", 32'(mem_size), 32'h2);
         chk("fetch_ack_early", 32'(if_ack), 0);
      end
      mem_ack = 1; mem_rd = 32'h00500093;
      tick();
      chk("fetch_ack", 32'(if_ack), 1);
      chk("fetch_rd", if_rd, 32'h00500093);
      mem_ack = 0; if_req = 0;
      tick();
      chk("fetch_ack_once", 32'(if_ack), 0);
      chk("fetch_rd_hold", if_rd, 32'h00500093);

      // Simultaneous requests: LSU store first, then IF
      if_req = 1; if_addr = 32'h104;
      lsu_req = 1; lsu_we = 1; lsu_addr = 32'h2000; lsu_wd = 32'hDEADBEEF; lsu_size = 2'b01;
      tick();
      chk("sim_lsu_we", 32'(mem_we), 1);
      chk("sim_lsu_size", 32'(mem_size), 32'h1);
      chk("sim_lsu_addr", mem_addr, 32'h2000);
      chk("sim_lsu_wd", mem_wd, 32'hDEADBEEF);
      mem_ack = 1; mem_rd = 32'h12345678;
      tick();
      chk("sim_lsu_ack", 32'(lsu_ack), 1);
      lsu_req = 0; mem_ack = 0;
      tick();
      tick();
      chk("sim_if_addr", mem_addr, 32'h104);
      chk("sim_if_we", 32'(mem_we), 0);
      mem_ack = 1; mem_rd = 32'hA5A5A5A5;
      tick();
      chk("sim_if_ack", 32'(if_ack), 1);
      if_req = 0; mem_ack = 0;
      tick();

      // Starvation with STARVE_MAX=2: both held, memory acks immediately
      gexp = '{2, 2, 1, 2, 2, 1};
      if_req = 1; if_addr = 32'h1000;
      lsu_req = 1; lsu_we = 0; lsu_addr = 32'h8000; lsu_size = 2'b10;
      gcnt = 0; prev_req = 0;
      for (int c = 0; c < 100 && gcnt < 6; c++) begin
         mem_ack = m_fly; mem_rd = $urandom;
         tick();
         if (mem_req && !prev_req) begin
            gord[gcnt] = (mem_addr == 32'h8000) ? 2 : 1;
            gcnt++;
         end
         prev_req = mem_req;
      end
      if_req = 0; lsu_req = 0;
      drain();
      tick();
      chk("starve_count", 32'(gcnt), 6);
      for (int i = 0; i < 6; i++) chk($sformatf("starve_order%0d", i), 32'(gord[i]), 32'(gexp[i]));

      // Stray ack in IDLE
      mem_ack = 1; mem_rd = 32'hFFFF0000;
      tick();
      mem_ack = 0;
      tick();
      chk("stray_if_ack", 32'(if_ack), 0);
      chk("stray_lsu_ack", 32'(lsu_ack), 0);
      chk("stray_busy", 32'(busy), 0);

      // Long wait in LSU_BUS with request fields changing after the grant
      lsu_req = 1; lsu_we = 0; lsu_addr = 32'h3000; lsu_size = 2'b10; lsu_wd = 32'h0;
      tick();
      lsu_addr = 32'h3FFC; lsu_we = 1; lsu_wd = 32'h55AA55AA; lsu_size = 2'b00;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("wait_addr", mem_addr, 32'h3000);
         chk("wait_we", 32'(mem_we), 0);
         chk("wait_ack", 32'(lsu_ack), 0);
      end

      // Reset mid-LSU_BUS: outputs drop immediately, no ack afterwards
      #2 resetn = 0;
      #1 check_zero();
      model_reset();
      lsu_req = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      resetn = 1;
      mem_ack = 1;
      tick();
      mem_ack = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("post_rst_lsu_ack", 32'(lsu_ack), 0);
      end

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         if (m_ifack) if_req = ($urandom_range(2) == 0);
         else if (!if_req) if_req = 1'($urandom_range(1));
         if ($urandom_range(1) == 1) if_addr = $urandom;
         if (m_lsuack) lsu_req = ($urandom_range(2) == 0);
         else if (!lsu_req) lsu_req = 1'($urandom_range(1));
         if ($urandom_range(1) == 1) begin
            lsu_addr = $urandom; lsu_wd = $urandom;
            lsu_we = 1'($urandom_range(1)); lsu_size = 2'($urandom_range(2));
         end
         mem_ack = m_fly ? ($urandom_range(2) == 0) : ($urandom_range(5) == 0);
         mem_rd = $urandom;
         tick();
      end
      if_req = 0; lsu_req = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/nf_mem_arb.md
# nf_mem_arb

Two-requester arbiter and sequencer for the core's single shared memory port. The instruction fetch path (IF) and the load/store path (LSU), driven by the decoder's `we_dm_en`/`size_dm`, compete for one memory bus. The block grants one transaction at a time, registers the winning request onto the bus, waits for the memory acknowledge, then returns read data with a one-cycle acknowledge pulse. LSU has priority, and a starvation counter guarantees IF forward progress.

## Interface
Parameters:
- `STARVE_MAX`, default 4: maximum consecutive LSU grants while IF is pending. Legal range is 1..15.

Ports:
- `clk` in 1: the single clock. All state updates on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `if_req` in 1: IF request. Held high until `if_ack`.
- `if_addr` in 32: fetch address.
- `if_ack` out 1: one-cycle completion pulse to IF.
- `if_rd` out 32: fetched word. Valid while `if_ack`=1.
- `lsu_req` in 1: LSU request. Held high until `lsu_ack`.
- `lsu_addr` in 32: LSU address.
- `lsu_wd` in 32: store data.
- `lsu_we` in 1: 1 = store, 0 = load.
- `lsu_size` in 2: access size (00 byte, 01 half, 10 word).
- `lsu_ack` out 1: one-cycle completion pulse to LSU.
- `lsu_rd` out 32: load data. Valid while `lsu_ack`=1.
- `mem_req` out 1: bus request. Registered.
- `mem_addr` out 32: bus address. Registered.
- `mem_wd` out 32: bus write data. Registered.
- `mem_we` out 1: bus write enable. Registered.
- `mem_size` out 2: bus access size. Registered.
- `mem_ack` in 1: memory completion. Valid only while `mem_req`=1.
- `mem_rd` in 32: memory read data. Valid with `mem_ack`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, IF_BUS, LSU_BUS, RESP. Reset state is IDLE.
- IDLE arbitration, sampled each cycle:
  - Only one request pending: grant it.
  - Both pending and `starve_cnt` < `STARVE_MAX`: grant LSU.
  - Both pending and `starve_cnt` == `STARVE_MAX`: grant IF.
- On grant:
  - Latch the bus fields.
  - IF grant drives `mem_we`=0, `mem_size`=10, `mem_wd`=0.
  - LSU grant drives `lsu_we`, `lsu_size` and `lsu_wd` unchanged.
  - Next state is IF_BUS or LSU_BUS. `mem_req`=1 from the next cycle.
- IF_BUS and LSU_BUS:
  - Bus fields and `mem_req` are held stable.
  - On `mem_ack`=1: capture `mem_rd` into the granted requester's rd register, set that requester's ack, clear `mem_req`, and go to RESP.
- RESP:
  - Lasts exactly one cycle with the ack high.
  - Requests are not sampled in RESP, which prevents a double grant from a request still held high.
  - Next state is IDLE.
- `starve_cnt` (4 bits) updates only on a grant:
  - LSU grant while `if_req`=1: `starve_cnt`+1, saturating at `STARVE_MAX`.
  - IF grant: cleared to 0.
  - LSU grant while `if_req`=0: cleared to 0.
- `mem_ack` in IDLE or RESP is ignored: no state change and no ack.
- Requester inputs that change after the grant have no effect on the transaction in flight.
- Reset asserted mid-transaction:
  - The transaction is abandoned. No ack is issued for it.
  - All outputs and `starve_cnt` return to reset values asynchronously.

## Timing
- Reset values are 0 on every output: `mem_req`, `mem_addr`, `mem_wd`, `mem_we`, `mem_size`, `if_ack`, `lsu_ack`, `if_rd`, `lsu_rd`, `busy`. `starve_cnt`=0.
- Transaction timeline, with the request sampled in IDLE at cycle 0:
  - `mem_req`=1 from cycle 1.
  - If `mem_ack`=1 in cycle k (k≥1), the ack and rd data are valid in cycle k+1 and `mem_req`=0 in cycle k+1.
  - The state is IDLE in cycle k+2.
- Minimum latency from request to ack is 2 cycles, with `mem_ack` in cycle 1.
- Minimum back-to-back spacing is one grant every 3 cycles.
- The requester must drop `req` in the cycle after its ack unless it is issuing a new request. A request high in cycle k+2 is treated as a new request.
- `if_rd` and `lsu_rd` hold their last value until overwritten.

## Test plan
- Reset: assert `resetn`=0 mid-LSU_BUS with `mem_req`=1 → all outputs 0 immediately; no `lsu_ack` after release.
- Single fetch: `if_req`=1 with `if_addr`=0x100 at cycle 0; memory acks at cycle 3 with `mem_rd`=0x00500093 → `mem_addr`=0x100, `mem_we`=0, `mem_size`=10 in cycles 1-3; `if_ack`=1 with `if_rd`=0x00500093 at cycle 4 only.
- Simultaneous requests: LSU store with `lsu_addr`=0x2000, `lsu_wd`=0xDEADBEEF, `lsu_size`=01, together with `if_req` → LSU granted first (`mem_we`=1, `mem_size`=01); IF granted in the IDLE following LSU's RESP.
- Starvation with `STARVE_MAX`=2: `if_req` held and `lsu_req` re-asserted every IDLE → grant order LSU, LSU, IF, LSU, …; `starve_cnt` returns to 0 after the IF grant.
- Stray ack: pulse `mem_ack`=1 while IDLE → no ack output, `busy` stays 0; hold `mem_ack`=0 for 10 cycles in LSU_BUS → bus fields stable, `lsu_ack` stays 0.
